// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap-or-saturate limits, parallel load and cascade outputs.
// Define COUNTER_PRESCALER_EN to add a PRESCALE-edge prescaler in front of each count step.
module updown_counter_param #(
   parameter int WIDTH     = 4,
   parameter int MAX_VALUE = 2**WIDTH-1,
   parameter bit SATURATE  = 1'b0,
   parameter int PRESCALE  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             direction,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] counter,
   output logic             terminal,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);

   if (WIDTH < 1 || WIDTH > 16) begin : gBadWidth
      $error("updown_counter_param: WIDTH must be 1..16");
   end
   if (MAX_VALUE < 0 || MAX_VALUE > 2**WIDTH-1) begin : gBadMax
      $error("updown_counter_param: MAX_VALUE must fit in WIDTH bits");
   end
   if (PRESCALE < 1 || PRESCALE > 256) begin : gBadPrescale
      $error("updown_counter_param: PRESCALE must be 1..256");
   end

   logic stepNow;

`ifdef COUNTER_PRESCALER_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE-1);

   logic [PW-1:0] prescaler;

   assign stepNow = enable && (prescaler == PS_LAST);

   // Prescaler phase: frozen while disabled, restarted by reset or load.
   always_ff @(negedge clock) begin
      if (!reset) begin
         prescaler <= '0;
      end else if (load) begin
         prescaler <= '0;
      end else if (enable) begin
         prescaler <= stepNow ? '0 : prescaler + 1'b1;
      end
   end
`else
   assign stepNow = enable;
`endif

   // terminal ignores enable so it can drive the next stage's enable when cascading.
   assign terminal = direction ? (counter == MAX) : (counter == '0);

   always_ff @(negedge clock) begin
      if (!reset) begin
         counter <= '0;
         wrap    <= 1'b0;
      end else if (load) begin
         counter <= (load_value > MAX) ? MAX : load_value;
         wrap    <= 1'b0;
      end else if (stepNow) begin
         if (direction) begin
            // An out-of-range value is treated as sitting on the upper limit.
            if (counter >= MAX) begin
               counter <= SATURATE ? MAX : '0;
               wrap    <= !SATURATE;
            end else begin
               counter <= counter + 1'b1;
               wrap    <= 1'b0;
            end
         end else begin
            if (counter == '0) begin
               counter <= SATURATE ? '0 : MAX;
               wrap    <= !SATURATE;
            end else begin
               counter <= counter - 1'b1;
               wrap    <= 1'b0;
            end
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: wrap, saturate, load, reset priority and prescaler.
module tb_updown_counter_param;

`ifdef COUNTER_PRESCALER_EN
   localparam int PS_DIV = 3;
`else
   localparam int PS_DIV = 1;
`endif

   logic       clock = 1'b0;
   logic       clockStop = 1'b0;
   logic       dutClock;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       direction = 1'b1;
   logic       load = 1'b0;
   logic [3:0] loadValue = '0;

   logic [3:0] counter0, counter1, counter2;
   logic       terminal0, terminal1, terminal2;
   logic       wrap0, wrap1, wrap2;

   int checks = 0;
   int errors = 0;
   int modelCnt = 0;
   int modelPs = 0;

   always #5 clock = ~clock;

   // Holding the gated clock high removes falling edges entirely.
   assign dutClock = clock | clockStop;

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) u0 (
      .clock(dutClock), .reset(reset), .enable(enable), .direction(direction),
      .load(load), .load_value(loadValue),
      .counter(counter0), .terminal(terminal0), .wrap(wrap0));

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(1'b1)) u1 (
      .clock(dutClock), .reset(reset), .enable(enable), .direction(direction),
      .load(load), .load_value(loadValue),
      .counter(counter1), .terminal(terminal1), .wrap(wrap1));

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0), .PRESCALE(3)) u2 (
      .clock(dutClock), .reset(reset), .enable(enable), .direction(direction),
      .load(load), .load_value(loadValue),
      .counter(counter2), .terminal(terminal2), .wrap(wrap2));

   // Inputs change at a rising edge; the DUT samples them at the following falling edge
   // and the task returns on the next rising edge, where outputs are stable.
   task automatic applyStimulus(input logic rst, input logic en, input logic dir,
                                input logic ld, input logic [3:0] lv);
      reset     = rst;
      enable    = en;
      direction = dir;
      load      = ld;
      loadValue = lv;
      @(posedge clock);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic prescaleEdge(input logic en, input string tag);
      applyStimulus(1'b1, en, 1'b1, 1'b0, 4'd0);
      if (en) begin
         if (modelPs == PS_DIV-1) begin
            modelPs  = 0;
            modelCnt = (modelCnt == 9) ? 0 : modelCnt + 1;
         end else begin
            modelPs++;
         end
      end
      checkOutput(tag, 32'(counter2), 32'(modelCnt));
   endtask

   initial begin
      @(posedge clock);

      // Reset state, counting up through the 9 -> 0 wrap.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      checkOutput("reset_counter", 32'(counter0), 32'd0);
      checkOutput("reset_wrap", 32'(wrap0), 32'd0);
      checkOutput("reset_terminal_up", 32'(terminal0), 32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
         checkOutput("up_counter", 32'(counter0), 32'((i + 1) % 10));
         checkOutput("up_wrap", 32'(wrap0), 32'(i == 9));
         checkOutput("up_terminal", 32'(terminal0), 32'(i == 8));
      end

      // Counting down from reset, then a clamped load.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("reset_terminal_down", 32'(terminal0), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("down_wrap_counter", 32'(counter0), 32'd9);
      checkOutput("down_wrap_pulse", 32'(wrap0), 32'd1);
      checkOutput("down_terminal_at9", 32'(terminal0), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("down_8", 32'(counter0), 32'd8);
      checkOutput("down_wrap_cleared", 32'(wrap0), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("down_7", 32'(counter0), 32'd7);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd14);
      checkOutput("load_clamped", 32'(counter0), 32'd9);
      checkOutput("load_wrap", 32'(wrap0), 32'd0);

      // Saturating instance holds at 15 and steps down afterwards.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("sat_reach15", 32'(counter1), 32'd15);
      checkOutput("sat_terminal", 32'(terminal1), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
         checkOutput("sat_hold", 32'(counter1), 32'd15);
         checkOutput("sat_nowrap", 32'(wrap1), 32'd0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("sat_down14", 32'(counter1), 32'd14);

      // Reset without clock edges does nothing; with an edge it beats load and enable.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("mid_count5", 32'(counter0), 32'd5);
      clockStop = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      checkOutput("no_async_reset", 32'(counter0), 32'd5);
      clockStop = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      checkOutput("reset_priority", 32'(counter0), 32'd0);
      checkOutput("reset_priority_wrap", 32'(wrap0), 32'd0);

      // Load wins over enable, then enable=0 holds.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      checkOutput("load_over_enable", 32'(counter0), 32'd3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
         checkOutput("hold_disabled", 32'(counter0), 32'd3);
         checkOutput("hold_wrap", 32'(wrap0), 32'd0);
      end

      // Prescaled instance: phase stretched by disabled edges and restarted by load.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      modelCnt = 0;
      modelPs  = 0;
      checkOutput("ps_reset", 32'(counter2), 32'd0);
      for (int i = 0; i < 7; i++) prescaleEdge(1'b1, "ps_enabled");
      prescaleEdge(1'b0, "ps_frozen_a");
      prescaleEdge(1'b0, "ps_frozen_b");
      prescaleEdge(1'b1, "ps_resume");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      modelCnt = 5;
      modelPs  = 0;
      checkOutput("ps_load", 32'(counter2), 32'd5);
      for (int i = 0; i < 3; i++) prescaleEdge(1'b1, "ps_after_load");
`ifdef COUNTER_PRESCALER_EN
      checkOutput("ps_final", 32'(counter2), 32'd6);
`else
      checkOutput("ps_final", 32'(counter2), 32'd8);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
